// File: rtl/player_pos_ctl.sv
// rtl/player_pos_ctl.sv - frame-rate sprite position controller
// Walk, jump and gravity are applied once per frame, on the rising edge of vblnk.
module player_pos_ctl #(
  parameter int SPRITE_W = 48,
  parameter int SPRITE_H = 64,
  parameter int X_START  = 376,
  parameter int X_MAX    = 800 - SPRITE_W,
  parameter int Y_GROUND = 600 - SPRITE_H,
  parameter int STEP_X   = 4,
  parameter int JUMP_V   = 16,
  parameter int GRAV     = 1,
  parameter int V_MAX    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_jump,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        airborne
);

  localparam int VW = $clog2(((JUMP_V > V_MAX) ? JUMP_V : V_MAX) + 1);

  localparam logic [11:0]   XS = 12'(X_START);
  localparam logic [11:0]   XM = 12'(X_MAX);
  localparam logic [11:0]   YG = 12'(Y_GROUND);
  localparam logic [11:0]   SX = 12'(STEP_X);
  localparam logic [VW-1:0] JV = VW'(JUMP_V);
  localparam logic [VW-1:0] GV = VW'(GRAV);
  localparam logic [VW:0]   VM = (VW+1)'(V_MAX);

  typedef enum logic [1:0] {GROUND, RISE, FALL} state_e;

  state_e        state_q, state_d;
  logic [11:0]   xpos_q, xpos_d;
  logic [11:0]   ypos_q, ypos_d;
  logic [VW-1:0] vel_q, vel_d;
  logic          airborne_q, airborne_d;
  logic          vblnk_q;

  logic          frame_tick;
  logic [11:0]   vel_ext;
  logic [11:0]   y_nxt;
  logic [VW:0]   vel_inc;

  assign frame_tick = vblnk & ~vblnk_q;
  assign vel_ext    = {{(12-VW){1'b0}}, vel_q};
  assign y_nxt      = ypos_q + vel_ext;
  assign vel_inc    = {1'b0, vel_q} + {1'b0, GV};

  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q    <= 1'b0;
      state_q    <= GROUND;
      xpos_q     <= XS;
      ypos_q     <= YG;
      vel_q      <= '0;
      airborne_q <= 1'b0;
    end else begin
      vblnk_q    <= vblnk;
      state_q    <= state_d;
      xpos_q     <= xpos_d;
      ypos_q     <= ypos_d;
      vel_q      <= vel_d;
      airborne_q <= airborne_d;
    end
  end

  always_comb begin
    state_d = state_q;
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;
    vel_d   = vel_q;
    if (frame_tick) begin
      if (btn_left && !btn_right) begin
        xpos_d = (xpos_q < SX) ? 12'd0 : xpos_q - SX;
      end else if (btn_right && !btn_left) begin
        xpos_d = (xpos_q + SX >= XM) ? XM : xpos_q + SX;
      end
      unique case (state_q)
        GROUND: begin
          ypos_d = YG;
          if (btn_jump) begin
            vel_d   = JV;
            state_d = RISE;
          end
        end
        RISE: begin
          // Clip at the top row rather than letting ypos wrap below zero.
          if (vel_ext > ypos_q) begin
            ypos_d  = 12'd0;
            vel_d   = '0;
            state_d = FALL;
          end else begin
            ypos_d = ypos_q - vel_ext;
            if (vel_q <= GV) begin
              vel_d   = '0;
              state_d = FALL;
            end else begin
              vel_d = vel_q - GV;
            end
          end
        end
        FALL: begin
          if (y_nxt >= YG) begin
            ypos_d  = YG;
            vel_d   = '0;
            state_d = GROUND;
          end else begin
            ypos_d = y_nxt;
            vel_d  = (vel_inc > VM) ? VM[VW-1:0] : vel_inc[VW-1:0];
          end
        end
        default: begin
          state_d = GROUND;
          ypos_d  = YG;
          vel_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    airborne_d = (state_d != GROUND);
  end

  assign xpos     = xpos_q;
  assign ypos     = ypos_q;
  assign airborne = airborne_q;

endmodule

// File: tb/tb_player_pos_ctl.sv
// tb/tb_player_pos_ctl.sv - directed-vector bench for player_pos_ctl
// Frame table plus hand-written walk, jump, long-vblnk and reset sequences.
module tb_player_pos_ctl;

  logic        clk = 1'b0;
  logic        rst, vblnk, btn_left, btn_right, btn_jump;
  logic [11:0] xpos, ypos, xpos_b, ypos_b;
  logic        airborne, airborne_b;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  player_pos_ctl dut (
    .clk(clk), .rst(rst), .vblnk(vblnk),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .xpos(xpos), .ypos(ypos), .airborne(airborne)
  );

  // Second instance starting near the left edge to exercise the clamp at 0.
  player_pos_ctl #(.X_START(2)) dut_b (
    .clk(clk), .rst(rst), .vblnk(vblnk),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .xpos(xpos_b), .ypos(ypos_b), .airborne(airborne_b)
  );

  typedef struct {
    bit l;
    bit r;
    bit j;
    int ex;
    int ey;
    int ea;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; vblnk = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic frame(input bit l, input bit r, input bit j);
    btn_left = l; btn_right = r; btn_jump = j;
    vblnk = 1'b1;
    step();
    btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
    step();
    vblnk = 1'b0;
    step();
    step();
  endtask

  task automatic chk_pos(input string name, input int ex, input int ey, input int ea);
    chk({name, ".x"}, int'(xpos), ex);
    chk({name, ".y"}, int'(ypos), ey);
    chk({name, ".air"}, int'(airborne), ea);
  endtask

  initial begin
    int ex, ey;
    vecs[0] = '{0, 0, 0, 376, 536, 0};
    vecs[1] = '{1, 0, 0, 372, 536, 0};
    vecs[2] = '{0, 1, 0, 376, 536, 0};
    vecs[3] = '{1, 1, 0, 376, 536, 0};
    vecs[4] = '{0, 1, 0, 380, 536, 0};
    vecs[5] = '{0, 1, 1, 384, 536, 1};
    vecs[6] = '{1, 0, 0, 380, 520, 1};
    vecs[7] = '{1, 0, 1, 376, 505, 1};
    vecs[8] = '{0, 0, 0, 376, 491, 1};

    do_reset();
    chk_pos("reset", 376, 536, 0);
    for (int i = 0; i < 10; i++) begin
      repeat (100) step();
      chk_pos($sformatf("idle%0d", i), 376, 536, 0);
    end

    for (int i = 0; i < 9; i++) begin
      frame(vecs[i].l, vecs[i].r, vecs[i].j);
      chk_pos($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].ea);
    end

    do_reset();
    frame(0, 0, 1);
    chk_pos("jump0", 376, 536, 1);
    for (int k = 1; k <= 16; k++) begin
      frame(0, 0, 0);
      chk_pos($sformatf("rise%0d", k), 376, 536 - (16*k - k*(k-1)/2), 1);
    end
    for (int k = 1; k <= 17; k++) begin
      frame(0, 0, 0);
      ey = (k == 17) ? 536 : 400 + k*(k-1)/2;
      chk_pos($sformatf("fall%0d", k), 376, ey, (k == 17) ? 0 : 1);
    end
    frame(0, 0, 0);
    chk_pos("landed", 376, 536, 0);

    frame(0, 0, 1);
    for (int k = 1; k <= 33; k++) frame(0, 0, 1);
    chk_pos("held_land", 376, 536, 0);
    frame(0, 0, 1);
    chk_pos("rejump", 376, 536, 1);

    do_reset();
    for (int k = 1; k <= 100; k++) begin
      frame(0, 1, 0);
      ex = (376 + 4*k > 752) ? 752 : 376 + 4*k;
      chk($sformatf("right%0d", k), int'(xpos), ex);
    end
    for (int k = 1; k <= 10; k++) begin
      frame(1, 1, 0);
      chk($sformatf("both%0d", k), int'(xpos), 752);
    end

    do_reset();
    for (int k = 1; k <= 95; k++) begin
      frame(1, 0, 0);
      ex = (376 - 4*k < 0) ? 0 : 376 - 4*k;
      chk($sformatf("left%0d", k), int'(xpos), ex);
      if (k <= 2) chk($sformatf("left_b%0d", k), int'(xpos_b), 0);
    end

    do_reset();
    btn_right = 1'b1; vblnk = 1'b1;
    step();
    chk_pos("vb_tick", 380, 536, 0);
    for (int c = 0; c < 499; c++) begin
      btn_left  = 1'($urandom_range(0, 1));
      btn_right = 1'($urandom_range(0, 1));
      btn_jump  = 1'($urandom_range(0, 1));
      step();
      if (c % 100 == 98) chk_pos($sformatf("vb_hold%0d", c), 380, 536, 0);
    end
    vblnk = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
    step();
    chk_pos("vb_end", 380, 536, 0);

    do_reset();
    frame(0, 1, 1);
    for (int k = 1; k <= 5; k++) frame(0, 0, 0);
    chk_pos("mid_rise", 380, 466, 1);
    rst = 1'b1;
    step();
    chk_pos("rst_mid", 376, 536, 0);
    rst = 1'b0;
    frame(0, 0, 0);
    chk_pos("after_rst", 376, 536, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
